dot_accum: RTL and testbench
============================

// Module: dot_accum
// PURPOSE
//   Downstream consumer of the 2-lane multiply/add pipeline. Accepts one signed
//   partial dot product per cycle and sums TERMS consecutive partials into a
//   full-length dot product. Emits each result once on a valid/ready output.
//   Sits between the MAC pipeline and the result writeback/collector.
// PARAMETERS
//   DATA_W  32  width of incoming partial sum (signed two's complement)
//   ACC_W   40  accumulator/result width; must be >= DATA_W
//   TERMS   4   partials per result; must be >= 2
// PORTS
//   clk        in   1       single clock; all state changes on posedge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       in_data holds a partial sum
//   in_data    in   DATA_W  signed partial sum from the MAC stage
//   in_ready   out  1       beat is accepted when in_valid && in_ready
//   out_valid  out  1       out_data/out_sat hold a completed result
//   out_data   out  ACC_W   signed dot product
//   out_ready  in   1       consumer takes result when out_valid && out_ready
//   out_sat    out  1       result was clipped (DOTACC_SAT_EN only)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, cnt=0, acc=0, out_valid=0,
//     out_data=0, out_sat=0. Reset mid-group discards the partial group.
//   - FSM: IDLE (no beats in group) -> ACCUM on an accepted beat when TERMS>1;
//     ACCUM stays while cnt<TERMS-1; final beat -> IDLE.
//   - in_data is sign-extended to ACC_W before any addition.
//   - First beat of a group: acc <= sext(in_data), cnt <= 1 (prior acc ignored).
//   - Middle beat: acc <= acc + sext(in), cnt <= cnt+1.
//   - Final beat (cnt==TERMS-1): out_data <= acc + sext(in), out_valid <= 1,
//     cnt <= 0, acc <= 0. Latency: result visible the cycle after the final
//     beat's posedge.
//   - in_ready = (cnt != TERMS-1) || !out_valid || out_ready (combinational).
//     Non-final beats are accepted even while a result is stalled; only the
//     final beat is blocked by a held result.
//   - Output hold: while out_valid && !out_ready, out_data/out_sat are stable.
//   - Handshake: if out_valid && out_ready and no final beat is accepted,
//     out_valid <= 0. If both happen in the same cycle, the new result replaces
//     the old one and out_valid stays 1. This gives full throughput with no bubble.
//   - Without saturation, sums wrap modulo 2^ACC_W.
//   - in_data is ignored when in_valid=0. A change of in_data while stalled
//     has no effect.
// CONFIGURATION
//   DOTACC_SAT_EN defined: every add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     A sticky group flag records any clip in the group. It is copied to out_sat
//     with the result and cleared at the start of the next group.
//   DOTACC_SAT_EN undefined: wrap-around arithmetic; out_sat is tied to 0.
//   The port list is identical in both builds.
// STRUCTURE
//   dot_pkg: state encoding (ST_IDLE, ST_ACCUM) and the default width and TERMS
//     constants, so the MAC stage and this block agree.
//   Sub-module sat_add (ACC_W): signed add with optional clip and a clip flag.
//     With DOTACC_SAT_EN undefined it is a plain adder with flag=0.
//   cnt width is $clog2(TERMS).
// TESTING (TERMS=4, ACC_W=40, DATA_W=32 unless noted)
//   1 in 1,2,3,4 back-to-back, out_ready=1 -> out_data=10, out_valid high
//     for 1 cycle, one cycle after beat 4.
//   2 in -5,3,-1,1 -> out_data=40'hFF_FFFF_FFFE (-2).
//   3 out_ready=0 after a result: next group's beats 1-3 are accepted and beat 4
//     sees in_ready=0. Raise out_ready: old result is taken, then a new result
//     follows with no lost beat.
//   4 Two groups streamed continuously, out_ready=1: results on consecutive
//     group boundaries with zero bubbles (8 beats -> 2 results in 9 cycles).
//   5 rst after 2 beats (7,7), then 1,1,1,1 -> out_data=4. No output for the
//     aborted group.
//   6 ACC_W=32, in 32'h7FFFFFFF,1,0,0:
//     with DOTACC_SAT_EN -> 32'h7FFFFFFF, out_sat=1; next group 1,1,1,1 -> out_sat=0.
//     without DOTACC_SAT_EN -> 32'h80000000, out_sat=0.

Source files
------------

// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot_pkg
// Purpose  : Shared state encoding and default sizing for the dot-product
//            accumulator, so the MAC stage and dot_accum agree on widths.
// Revision : 1.0 - initial release
// ============================================================================
package dot_pkg;

  // Accumulator group state: IDLE means no beats of a group seen yet.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam int c_dot_data_w = 32;
  localparam int c_dot_acc_w  = 40;
  localparam int c_dot_terms  = 4;

endpackage
`default_nettype wire

// File: rtl/dot_accum_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : sat_add
// Purpose  : W-bit signed adder. With DOTACC_SAT_EN defined the sum clips to
//            the signed W-bit range and clip flags a clipped result; otherwise
//            it wraps modulo 2^W and clip is always 0.
// Revision : 1.0 - initial release
// ============================================================================
module sat_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         clip
);

`ifdef DOTACC_SAT_EN
  logic [W:0] w_full;

  assign w_full = {a[W-1], a} + {b[W-1], b};

  // Overflow shows as disagreement between the guard bit and the sign bit;
  // the guard bit gives the true sign and therefore the rail to clip to.
  always_comb begin
    sum  = w_full[W-1:0];
    clip = 1'b0;
    if (w_full[W] != w_full[W-1]) begin
      clip = 1'b1;
      sum  = w_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign sum  = a + b;
  assign clip = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : dot_accum
// Purpose  : Sums TERMS consecutive signed partial dot products into one
//            result presented on a valid/ready output. Non-final beats keep
//            flowing while a result is stalled; only the final beat waits.
// Config   : DOTACC_SAT_EN - saturating adds with sticky clip flag on out_sat;
//            undefined gives wrap-around arithmetic and out_sat = 0.
// Revision : 1.0 - initial release
// ============================================================================
module dot_accum
  import dot_pkg::*;
#(
  parameter int DATA_W = c_dot_data_w,
  parameter int ACC_W  = c_dot_acc_w,
  parameter int TERMS  = c_dot_terms
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              out_sat
);

  localparam int                CNT_W  = $clog2(TERMS);
  localparam logic [CNT_W-1:0]  c_last = CNT_W'(TERMS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_grp_sat;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_out_sat;

  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W-1:0]   w_sum;
  logic               w_clip;
  logic               w_first;
  logic               w_last;
  logic               w_fire;

  assign w_ext   = ACC_W'($signed(in_data));
  assign w_first = (r_state == ST_IDLE);
  assign w_last  = (r_cnt == c_last);
  // The first beat of a group starts from zero, ignoring any stale accumulator.
  assign w_base  = w_first ? '0 : r_acc;

  assign in_ready = !w_last || !r_out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a    (w_base),
    .b    (w_ext),
    .sum  (w_sum),
    .clip (w_clip)
  );

  // Group FSM, accumulator and registered result with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_grp_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_fire) begin
        if (w_last) begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_acc     <= '0;
          r_grp_sat <= 1'b0;
        end else begin
          r_state   <= ST_ACCUM;
          r_cnt     <= r_cnt + CNT_W'(1);
          r_acc     <= w_sum;
          r_grp_sat <= w_first ? w_clip : (r_grp_sat | w_clip);
        end
      end

      // A new result may replace one being taken in the same cycle.
      if (w_fire && w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sum;
        r_out_sat   <= r_grp_sat | w_clip;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_accum
// Purpose  : Directed self-checking bench for dot_accum (TERMS=4) with a
//            second instance at ACC_W=32 for the overflow behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [39:0] out_data;
  logic        out_ready = 1'b1;
  logic        out_sat;

  logic        s_in_valid = 1'b0;
  logic [31:0] s_in_data = '0;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic        s_out_ready = 1'b1;
  logic        s_out_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dot_accum #(.DATA_W(32), .ACC_W(40), .TERMS(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_sat(out_sat)
  );

  dot_accum #(.DATA_W(32), .ACC_W(32), .TERMS(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(s_out_ready), .out_sat(s_out_sat)
  );

  // Advance to just after the next posedge, when registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present four beats back-to-back (caller guarantees in_ready) on a DUT.
  task automatic feed4(input bit narrow, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      if (narrow) begin s_in_valid = 1'b1; s_in_data = v[i]; end
      else        begin in_valid   = 1'b1; in_data   = v[i]; end
      tick();
    end
    in_valid = 1'b0;
    s_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 40'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", out_sat); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic_sum();
    logic [31:0] v [4];
    v[0] = 32'd1; v[1] = 32'd2; v[2] = 32'd3; v[3] = 32'd4;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = v[i];
      tick();
      if (i < 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid beat=%0d got=%b want=0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 40'd10) begin bad++; $display("FAIL basic_data got=%0d want=10", out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b want=0", out_valid); end
  endtask

  task automatic test_negative();
    // Garbage on in_data without in_valid must not disturb the next group.
    in_valid = 1'b0; in_data = 32'd999;
    tick();
    tick();
    feed4(1'b0, -32'sd5, 32'd3, -32'sd1, 32'd1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 40'hFF_FFFF_FFFE) begin bad++; $display("FAIL neg_data got=%h want=fffffffffe", out_data); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    feed4(1'b0, 32'd5, 32'd6, 32'd7, 32'd8);
    total++; if (out_valid !== 1'b1 || out_data !== 40'd26) begin bad++; $display("FAIL stall_first got=%b/%0d want=1/26", out_valid, out_data); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'd1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_mid_ready beat=%0d got=%b want=1", i, in_ready); end
      tick();
    end
    in_valid = 1'b1; in_data = 32'd2;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_final_ready got=%b want=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 40'd26) begin bad++; $display("FAIL stall_hold got=%b/%0d want=1/26", out_valid, out_data); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 40'd5) begin bad++; $display("FAIL stall_new got=%b/%0d want=1/5", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [8];
    int nres;
    bit stalled;
    v[0] = 32'd1;  v[1] = 32'd2;  v[2] = 32'd3;  v[3] = 32'd4;
    v[4] = 32'd10; v[5] = 32'd20; v[6] = 32'd30; v[7] = 32'd40;
    nres = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; in_data = v[k];
        #1;
        if (in_ready !== 1'b1) stalled = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) nres++;
      if (k == 3) begin
        total++; if (out_valid !== 1'b1 || out_data !== 40'd10) begin bad++; $display("FAIL b2b_first got=%b/%0d want=1/10", out_valid, out_data); end
      end
      if (k == 4) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", out_valid); end
      end
      if (k == 7) begin
        total++; if (out_valid !== 1'b1 || out_data !== 40'd100) begin bad++; $display("FAIL b2b_second got=%b/%0d want=1/100", out_valid, out_data); end
      end
    end
    total++; if (nres != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", nres); end
    total++; if (stalled) begin bad++; $display("FAIL b2b_ready got=stalled want=never"); end
    tick();
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_data = 32'd7;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_abort_valid got=%b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_abort_idle got=%b want=0", out_valid); end
    feed4(1'b0, 32'd1, 32'd1, 32'd1, 32'd1);
    total++; if (out_valid !== 1'b1 || out_data !== 40'd4) begin bad++; $display("FAIL rst_regroup got=%b/%0d want=1/4", out_valid, out_data); end
    tick();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_data;
    logic        exp_sat;
`ifdef DOTACC_SAT_EN
    exp_data = 32'h7FFF_FFFF; exp_sat = 1'b1;
`else
    exp_data = 32'h8000_0000; exp_sat = 1'b0;
`endif
    s_out_ready = 1'b1;
    feed4(1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    total++; if (s_out_valid !== 1'b1 || s_out_data !== exp_data) begin bad++; $display("FAIL ovf_data got=%b/%h want=1/%h", s_out_valid, s_out_data, exp_data); end
    total++; if (s_out_sat !== exp_sat) begin bad++; $display("FAIL ovf_sat got=%b want=%b", s_out_sat, exp_sat); end
    feed4(1'b1, 32'd1, 32'd1, 32'd1, 32'd1);
    total++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd4) begin bad++; $display("FAIL ovf_next_data got=%b/%0d want=1/4", s_out_valid, s_out_data); end
    total++; if (s_out_sat !== 1'b0) begin bad++; $display("FAIL ovf_next_sat got=%b want=0", s_out_sat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_negative();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
